maze_wall_engine: RTL and testbench

Parametrised, table-driven maze wall block for the VGA maze demo. It replaces per-region hard-coded wall logic with a writable table of `NUM_WALLS` rectangles. It drives a pipelined pixel-enable for the renderer, and runs a sequential collision scan on request that returns registered `stop_*` flags to the ball controller. It sits between the VGA timing generator / ball position logic and the colour mux.

---
 rtl/maze_pkg.sv | 31 +++
 rtl/maze_wall_cmp.sv | 41 ++++
 rtl/maze_wall_engine.sv | 145 ++++++++++++++
 tb/tb_maze_wall_engine.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types for the maze wall engine: wall table entry, contact flags, scan FSM states.
package maze_pkg;

    localparam int DEF_COORD_W  = 11;
    // Internal coordinate width; port coordinates are zero-extended into it.
    localparam int WALL_COORD_W = 16;

    typedef logic [WALL_COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   valid;
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } wall_t;

    typedef struct packed {
        logic right;
        logic left;
        logic up;
        logic down;
    } contact_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

endpackage

// File: rtl/maze_wall_cmp.sv
// Combinational test of one wall rectangle against a point (interior hit)
// and against a ball whose top-left corner is that point (contact faces).
module maze_wall_cmp
    import maze_pkg::*;
(
    input  wall_t    wall,
    input  coord_t   px,
    input  coord_t   py,
    input  coord_t   bw,
    output logic     hit,
    output contact_t contact
);

    // One extra bit so ball-end and bound+1 sums never wrap.
    typedef logic [WALL_COORD_W:0] ext_t;

    ext_t x, y, x_end, y_end, x0p1, y0p1, x1, y1;
    logic ox, oy;

    assign x     = ext_t'(px);
    assign y     = ext_t'(py);
    assign x_end = ext_t'(px) + ext_t'(bw);
    assign y_end = ext_t'(py) + ext_t'(bw);
    assign x0p1  = ext_t'(wall.x0) + ext_t'(1);
    assign y0p1  = ext_t'(wall.y0) + ext_t'(1);
    assign x1    = ext_t'(wall.x1);
    assign y1    = ext_t'(wall.y1);

    assign oy = (y_end > y0p1) && (y < y1);
    assign ox = (x_end > x0p1) && (x < x1);

    assign hit = wall.valid
                 && (wall.x0 < px) && (px < wall.x1)
                 && (wall.y0 < py) && (py < wall.y1);

    assign contact.right = wall.valid && (x_end == x0p1) && oy;
    assign contact.left  = wall.valid && (x == x1) && oy;
    assign contact.down  = wall.valid && (y_end == y0p1) && ox;
    assign contact.up    = wall.valid && (y == y1) && ox;

endmodule

// File: rtl/maze_wall_engine.sv
// Table-driven maze walls: parallel per-pixel wall enable plus a sequential
// per-entry collision scan that reports registered stop_* flags.
module maze_wall_engine
    import maze_pkg::*;
#(
    parameter int NUM_WALLS = 32,
    parameter int COORD_W   = DEF_COORD_W,
    parameter int BALL_W    = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [COORD_W-1:0]           hcounter,
    input  logic [COORD_W-1:0]           vcounter,
    output logic                         enable,
    input  logic                         wr_en,
    output logic                         wr_ready,
    input  logic [$clog2(NUM_WALLS)-1:0] wr_idx,
    input  logic                         wr_valid,
    input  logic [COORD_W-1:0]           wr_x0,
    input  logic [COORD_W-1:0]           wr_x1,
    input  logic [COORD_W-1:0]           wr_y0,
    input  logic [COORD_W-1:0]           wr_y1,
    input  logic                         check_req,
    input  logic [COORD_W-1:0]           x_ball,
    input  logic [COORD_W-1:0]           y_ball,
    input  logic [BALL_W-1:0]            ball_width,
    output logic                         busy,
    output logic                         check_valid,
    output logic                         stop_right,
    output logic                         stop_left,
    output logic                         stop_up,
    output logic                         stop_down
);

    localparam int IDX_W = $clog2(NUM_WALLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WALLS - 1);

    wall_t          walls_q [NUM_WALLS];
    state_t         state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    coord_t         ball_x_q, ball_y_q, ball_w_q;
    contact_t       acc_q, stop_q, scan_contact;
    logic           scan_hit_unused;
    logic [NUM_WALLS-1:0] pix_hit;
    contact_t       pix_contact_unused [NUM_WALLS];
    logic           wr_fire;

    assign busy     = (state_q != IDLE);
    assign wr_ready = !busy;
    assign wr_fire  = wr_en && wr_ready && (int'(wr_idx) < NUM_WALLS);

    assign stop_right = stop_q.right;
    assign stop_left  = stop_q.left;
    assign stop_up    = stop_q.up;
    assign stop_down  = stop_q.down;

    for (genvar i = 0; i < NUM_WALLS; i++) begin : g_pix
        maze_wall_cmp u_cmp (
            .wall    (walls_q[i]),
            .px      (coord_t'(hcounter)),
            .py      (coord_t'(vcounter)),
            .bw      ('0),
            .hit     (pix_hit[i]),
            .contact (pix_contact_unused[i])
        );
    end

    maze_wall_cmp u_scan_cmp (
        .wall    (walls_q[idx_q]),
        .px      (ball_x_q),
        .py      (ball_y_q),
        .bw      (ball_w_q),
        .hit     (scan_hit_unused),
        .contact (scan_contact)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (check_req) state_d = SCAN;
            SCAN:    if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_WALLS; i++) begin
                walls_q[i] <= '0;
            end
            idx_q       <= '0;
            ball_x_q    <= '0;
            ball_y_q    <= '0;
            ball_w_q    <= '0;
            acc_q       <= '0;
            stop_q      <= '0;
            check_valid <= 1'b0;
            enable      <= 1'b0;
        end else begin
            enable      <= |pix_hit;
            check_valid <= (state_q == DONE);

            // A write in the same IDLE cycle as check_req lands before entry 0 is scanned.
            if (wr_fire) begin
                walls_q[wr_idx] <= '{valid: wr_valid,
                                     x0:    coord_t'(wr_x0),
                                     x1:    coord_t'(wr_x1),
                                     y0:    coord_t'(wr_y0),
                                     y1:    coord_t'(wr_y1)};
            end

            case (state_q)
                IDLE: begin
                    if (check_req) begin
                        ball_x_q <= coord_t'(x_ball);
                        ball_y_q <= coord_t'(y_ball);
                        ball_w_q <= coord_t'(ball_width);
                        acc_q    <= '0;
                        idx_q    <= '0;
                    end
                end
                SCAN: begin
                    acc_q <= acc_q | scan_contact;
                    if (idx_q != LAST_IDX) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    stop_q <= acc_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_wall_engine.sv
// Directed-vector bench for maze_wall_engine; scan results go through a
// scoreboard queue checked by an independent monitor.
module tb_maze_wall_engine;

    localparam int NW = 6;
    localparam int CW = 11;
    localparam int BW = 5;
    localparam int IW = $clog2(NW);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] hcounter, vcounter;
    logic          enable;
    logic          wr_en, wr_ready, wr_valid;
    logic [IW-1:0] wr_idx;
    logic [CW-1:0] wr_x0, wr_x1, wr_y0, wr_y1;
    logic          check_req;
    logic [CW-1:0] x_ball, y_ball;
    logic [BW-1:0] ball_width;
    logic          busy, check_valid;
    logic          stop_right, stop_left, stop_up, stop_down;

    maze_wall_engine #(
        .NUM_WALLS (NW),
        .COORD_W   (CW),
        .BALL_W    (BW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hcounter    (hcounter),
        .vcounter    (vcounter),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_idx      (wr_idx),
        .wr_valid    (wr_valid),
        .wr_x0       (wr_x0),
        .wr_x1       (wr_x1),
        .wr_y0       (wr_y0),
        .wr_y1       (wr_y1),
        .check_req   (check_req),
        .x_ball      (x_ball),
        .y_ball      (y_ball),
        .ball_width  (ball_width),
        .busy        (busy),
        .check_valid (check_valid),
        .stop_right  (stop_right),
        .stop_left   (stop_left),
        .stop_up     (stop_up),
        .stop_down   (stop_down)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0] stops;  // {right, left, up, down}
        int         due;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every check_valid pulse must match the oldest expected scan.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (check_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_check_valid: got pulse at cycle %0d, expected none", cyc);
                end else begin
                    e = sb_q.pop_front();
                    check({e.name, "_stops"},
                          {28'd0, stop_right, stop_left, stop_up, stop_down}, {28'd0, e.stops});
                    check({e.name, "_latency"}, cyc, e.due);
                    check({e.name, "_busy_low"}, busy, 0);
                end
            end
        end
    end

    task automatic write_entry(input int idx, input logic v, input int x0, input int x1,
                               input int y0, input int y1);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = IW'(idx);
        wr_valid = v;
        wr_x0    = CW'(x0);
        wr_x1    = CW'(x1);
        wr_y0    = CW'(y0);
        wr_y1    = CW'(y1);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // check_req is sampled at the next posedge (edge 0); check_valid is then
    // visible just after edge NW+1, i.e. when cyc reaches cyc_now + NW + 2.
    task automatic start_check(input string name, input int x, input int y, input int bw,
                               input logic [3:0] stops, input bit push);
        exp_t e;
        @(negedge clk);
        check_req  = 1'b1;
        x_ball     = CW'(x);
        y_ball     = CW'(y);
        ball_width = BW'(bw);
        if (push) begin
            e.stops = stops;
            e.due   = cyc + NW + 2;
            e.name  = name;
            sb_q.push_back(e);
        end
        @(negedge clk);
        check_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic set_pixel(input int h, input int v, input logic exp_en, input string name);
        @(negedge clk);
        hcounter = CW'(h);
        vcounter = CW'(v);
        @(posedge clk);
        #1;
        check(name, enable, exp_en);
    endtask

    initial begin
        rst_n      = 1'b0;
        hcounter   = '0;
        vcounter   = '0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_valid   = 1'b0;
        wr_x0      = '0;
        wr_x1      = '0;
        wr_y0      = '0;
        wr_y1      = '0;
        check_req  = 1'b0;
        x_ball     = '0;
        y_ball     = '0;
        ball_width = '0;
        #1;
        check("rst_enable", enable, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 1);
        check("rst_check_valid", check_valid, 0);
        check("rst_stops", {stop_right, stop_left, stop_up, stop_down}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Pixel path against entry 0 = (610, 620, 20, 490).
        write_entry(0, 1'b1, 610, 620, 20, 490);
        @(negedge clk);
        hcounter = CW'(615);
        vcounter = CW'(100);
        #1;
        check("enable_not_yet", enable, 0);
        @(posedge clk);
        #1;
        check("enable_inside", enable, 1);
        set_pixel(610, 100, 1'b0, "enable_h_edge");
        set_pixel(615, 490, 1'b0, "enable_v_edge");
        set_pixel(619, 489, 1'b1, "enable_inner_corner");
        write_entry(0, 1'b0, 610, 620, 20, 490);
        set_pixel(615, 100, 1'b0, "enable_invalid_entry");
        write_entry(7, 1'b1, 0, 1000, 0, 1000);
        set_pixel(615, 100, 1'b0, "enable_oob_write");
        write_entry(0, 1'b1, 610, 620, 20, 490);
        set_pixel(615, 100, 1'b1, "enable_restored");
        set_pixel(0, 0, 1'b0, "enable_origin");

        // Horizontal contacts with entry 0.
        start_check("right", 601, 100, 10, 4'b1000, 1'b1);
        wait_idle("right");
        start_check("left", 620, 100, 10, 4'b0100, 1'b1);
        wait_idle("left");

        // Vertical contacts with entry 1 = (548, 620, 150, 160).
        write_entry(1, 1'b1, 548, 620, 150, 160);
        start_check("down", 560, 141, 10, 4'b0001, 1'b1);
        wait_idle("down");
        start_check("up", 560, 160, 10, 4'b0010, 1'b1);
        wait_idle("up");
        start_check("corner_none", 539, 141, 10, 4'b0000, 1'b1);
        wait_idle("corner_none");
        start_check("multi_or", 601, 141, 10, 4'b1001, 1'b1);
        wait_idle("multi_or");

        // Write and request in the same IDLE cycle: scan sees entry 2.
        @(negedge clk);
        wr_en      = 1'b1;
        wr_idx     = IW'(2);
        wr_valid   = 1'b1;
        wr_x0      = CW'(300);
        wr_x1      = CW'(400);
        wr_y0      = CW'(300);
        wr_y1      = CW'(400);
        check_req  = 1'b1;
        x_ball     = CW'(291);
        y_ball     = CW'(350);
        ball_width = BW'(10);
        begin
            exp_t e;
            e.stops = 4'b1000;
            e.due   = cyc + NW + 2;
            e.name  = "simul_wr_chk";
            sb_q.push_back(e);
        end
        @(negedge clk);
        wr_en     = 1'b0;
        check_req = 1'b0;
        wait_idle("simul_wr_chk");

        // Busy protocol: mid-scan request and write are both dropped.
        start_check("busy_scan", 601, 100, 10, 4'b1000, 1'b1);
        check("busy_high", busy, 1);
        check("wr_ready_low", wr_ready, 0);
        @(negedge clk);
        check_req  = 1'b1;
        x_ball     = CW'(620);
        y_ball     = CW'(100);
        wr_en      = 1'b1;
        wr_idx     = IW'(0);
        wr_valid   = 1'b0;
        @(negedge clk);
        check_req = 1'b0;
        wr_en     = 1'b0;
        wait_idle("busy_scan");
        repeat (NW + 4) @(negedge clk);
        start_check("readback", 601, 100, 10, 4'b1000, 1'b1);
        wait_idle("readback");

        // Reset asserted mid-scan.
        set_pixel(615, 100, 1'b1, "enable_pre_reset");
        start_check("rst_scan", 601, 100, 10, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_enable", enable, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_ready", wr_ready, 1);
        check("midrst_check_valid", check_valid, 0);
        check("midrst_stops", {stop_right, stop_left, stop_up, stop_down}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("enable_after_reset", enable, 0);
        start_check("post_reset", 601, 100, 10, 4'b0000, 1'b1);
        wait_idle("post_reset");
        repeat (NW + 4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
        $fatal(1);
    end

endmodule
